// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and the
// counter-width helper.
package serial_subtractor_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bit counter must hold 0..WIDTH, hence clog2(WIDTH+1).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_sub.sv
// One-bit combinational full subtractor: d = a - b - bi, bo = borrow out.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  // Difference bit and borrow-out from the current operand bits.
  always_comb begin
    d  = a ^ b ^ bi;
    bo = (~a & b) | (~(a ^ b) & bi);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Handshake: start is sampled only in IDLE; busy is high in RUN and DONE;
// done is a one-cycle pulse in DONE, during which diff/borrow are valid.
// diff/borrow are only updated on the completion edge (or cleared by reset)
// and hold otherwise, including through the next operation's RUN.
// dbg_state exposes the FSM state encoding for checkers.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic [1:0]       dbg_state
);

  localparam int CW = cnt_width(WIDTH);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_bi;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             w_d;
  logic             w_bo;
  logic             w_last;

  // The single bit-slice working on the current LSBs.
  full_sub u_full_sub (
    .a  (r_a[0]),
    .b  (r_b[0]),
    .bi (r_bi),
    .d  (w_d),
    .bo (w_bo)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE after WIDTH bits,
  // DONE -> IDLE unconditionally.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register plus datapath: capture, shift, count and result load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_bi     <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_bi  <= 1'b0;
            r_cnt <= '0;
          end
        end
        ST_RUN: begin
          r_res <= {w_d, r_res[WIDTH-1:1]};
          r_a   <= {1'b0, r_a[WIDTH-1:1]};
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
          r_bi  <= w_bo;
          r_cnt <= r_cnt + CW'(1);
          // Completion edge: the result register including this edge's bit.
          if (w_last) begin
            r_diff   <= {w_d, r_res[WIDTH-1:1]};
            r_borrow <= w_bo;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign diff      = r_diff;
  assign borrow    = r_borrow;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4): reset state, a vector
// table, held-start / ignored-start / operand-change sequences, mid-RUN
// reset, reset+start collision, and an exhaustive sweep.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [W:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_diff;
    logic         exp_borrow;
  } vec_t;

  vec_t vecs[8];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow    (borrow),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one start pulse, then follow the operation until busy falls.
  // done_idx: edges after the start edge at which done was first seen (-1 if none).
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        output int done_idx, output int busy_cycles);
    a = ia;
    b = ib;
    start = 1'b1;
    tick();
    start = 1'b0;
    done_idx = -1;
    busy_cycles = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy) busy_cycles++;
      if (done && done_idx < 0) begin
        done_idx = k;
        if (exp_q.size() > 0) begin
          logic [W:0] e;
          e = exp_q.pop_front();
          check("sb_result", {borrow, diff}, e);
        end
      end
      if (!busy) break;
      tick();
    end
  endtask

  initial begin
    int di;
    int bc;
    int sweep_err0;
    logic [W-1:0] ta;
    logic [W-1:0] tb;

    vecs[0] = '{4'd9,  4'd3,  4'd6,  1'b0};
    vecs[1] = '{4'd3,  4'd9,  4'd10, 1'b1};
    vecs[2] = '{4'd0,  4'd1,  4'd15, 1'b1};
    vecs[3] = '{4'd15, 4'd15, 4'd0,  1'b0};
    vecs[4] = '{4'd7,  4'd0,  4'd7,  1'b0};
    vecs[5] = '{4'd0,  4'd15, 4'd1,  1'b1};
    vecs[6] = '{4'd15, 4'd0,  4'd15, 1'b0};
    vecs[7] = '{4'd8,  4'd9,  4'd15, 1'b1};

    // Reset
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b0;
    tick();

    // Vector table
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, di, bc);
      check("vec_done_idx", di, W);
      check("vec_busy_cycles", bc, W + 1);
      check("vec_diff", diff, vecs[i].exp_diff);
      check("vec_borrow", borrow, vecs[i].exp_borrow);
    end

    // Outputs hold during the next operation's RUN (last result: 15, borrow 1)
    a = 4'd9;
    b = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("hold_diff_in_run", diff, 15);
    check("hold_borrow_in_run", borrow, 1);
    for (int k = 0; k < 10 && busy; k++) tick();
    check("hold_then_new_diff", diff, 6);

    // Start held high; operands changed after E0; accepted again at E6
    a = 4'd9;
    b = 4'd3;
    start = 1'b1;
    tick();               // E0
    a = 4'd1;
    b = 4'd14;
    check("held_busy_e0", busy, 1);
    tick(); tick(); tick();  // E1..E3
    check("held_no_done_e3", done, 0);
    tick();               // E4
    check("held_done_e4", done, 1);
    check("held_diff", diff, 6);
    check("held_borrow", borrow, 0);
    tick();               // E5
    check("held_idle_e5", busy, 0);
    check("held_done_off_e5", done, 0);
    tick();               // E6: second accept with a=1, b=14
    check("held_reaccept_e6", busy, 1);
    start = 1'b0;
    for (int k = 0; k < 10 && !done; k++) tick();
    check("held2_done", done, 1);
    check("held2_diff", diff, 3);
    check("held2_borrow", borrow, 1);
    tick();
    tick();

    // Mid-RUN reset at the 3rd RUN edge
    a = 4'd2;
    b = 4'd5;
    start = 1'b1;
    tick();               // E0
    start = 1'b0;
    tick();               // E1
    tick();               // E2
    reset = 1'b1;
    tick();               // E3 with reset
    reset = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_diff", diff, 0);
    check("mid_rst_borrow", borrow, 0);
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
        if (done || busy) seen++;
        tick();
      end
      check("mid_rst_no_done", seen, 0);
    end
    run_op(4'd12, 4'd5, di, bc);
    check("post_rst_done_idx", di, W);
    check("post_rst_diff", diff, 7);
    check("post_rst_borrow", borrow, 0);

    // Reset and start on the same edge: start is lost
    a = 4'd1;
    b = 4'd2;
    start = 1'b1;
    reset = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b0;
    check("rst_start_busy", busy, 0);
    tick();
    check("rst_start_still_idle", busy, 0);

    // Exhaustive sweep through the expected queue
    sweep_err0 = n_errors;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        ta = W'(i);
        tb = W'(j);
        exp_q.push_back({(i < j) ? 1'b1 : 1'b0, W'((i - j) & 15)});
        run_op(ta, tb, di, bc);
        if (di < 0) check("sweep_done_timeout", di, W);
      end
    end
    check("sweep_queue_empty", exp_q.size(), 0);
    if (n_errors == sweep_err0) $display("Exhaustive sweep PASSED");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
